// File: rtl/la_pkg.sv
// Shared constants, defaults and FSM encoding for the acquisition/readout path.
package la_pkg;

  localparam int LA_ADDR_W = 10;
  localparam int LA_DATA_W = 8;

  localparam logic [LA_ADDR_W-1:0] LAST_ADDR = '1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LATCH,
    SEND,
    CSUM,
    DONE
  } state_t;

endpackage

// File: rtl/readout_addr_cntr.sv
// RAM read address counter: synchronous clear beats increment; last flags the final address.
// Latency: q updates on the edge after clr/inc; no backpressure of its own.
module readout_addr_cntr
  import la_pkg::*;
#(
  parameter int ADDR_W = LA_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              inc,
  output logic [ADDR_W-1:0] q,
  output logic              last
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= q + 1'b1;
    end
  end

  assign last = &q;

endmodule

// File: rtl/readout.sv
// Drains the sample RAM in address order onto a valid/ready byte stream, then pulses done_rd.
// Latency: grant sampled at edge k -> first handshake possible at edge k+3, 3 cycles/byte minimum;
// backpressure: tx_valid/tx_data hold until tx_ready. READOUT_CHECKSUM_EN appends a zero-sum byte.
module readout
  import la_pkg::*;
#(
  parameter int ADDR_W = LA_ADDR_W,
  parameter int DATA_W = LA_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              grant_rd,
  output logic              done_rd,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy
);

  state_t state;
  logic   cnt_clr;
  logic   cnt_inc;
  logic   last;
  logic   send_hs;

  assign send_hs = (state == SEND) && tx_ready;
  assign cnt_clr = ((state == IDLE) && grant_rd) || (state == DONE);
  assign cnt_inc = send_hs && !last;

  readout_addr_cntr #(
    .ADDR_W(ADDR_W)
  ) u_addr_cntr (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr),
    .inc (cnt_inc),
    .q   (rd_addr),
    .last(last)
  );

`ifdef READOUT_CHECKSUM_EN
  logic [DATA_W-1:0] sum;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum <= '0;
    end else if (state == IDLE) begin
      sum <= '0;
    end else if (send_hs) begin
      sum <= sum + tx_data;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rd_en    <= 1'b0;
      tx_data  <= '0;
      tx_valid <= 1'b0;
      done_rd  <= 1'b0;
      busy     <= 1'b0;
    end else begin
      rd_en   <= 1'b0;
      done_rd <= 1'b0;
      case (state)
        IDLE: begin
          if (grant_rd) begin
            state <= FETCH;
            rd_en <= 1'b1;
            busy  <= 1'b1;
          end
        end
        FETCH: begin
          state <= LATCH;
        end
        LATCH: begin
          tx_data  <= rd_data;
          tx_valid <= 1'b1;
          state    <= SEND;
        end
        SEND: begin
          if (tx_ready) begin
            if (last) begin
`ifdef READOUT_CHECKSUM_EN
              // tx_valid stays high: the checksum byte follows with no gap
              tx_data <= ~(sum + tx_data) + 1'b1;
              state   <= CSUM;
`else
              tx_valid <= 1'b0;
              done_rd  <= 1'b1;
              state    <= DONE;
`endif
            end else begin
              tx_valid <= 1'b0;
              rd_en    <= 1'b1;
              state    <= FETCH;
            end
          end
        end
`ifdef READOUT_CHECKSUM_EN
        CSUM: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            done_rd  <= 1'b1;
            state    <= DONE;
          end
        end
`endif
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          tx_valid <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_readout.sv
// Scoreboard bench for readout: expected bytes are queued when a frame is granted and popped on each handshake.
module tb_readout;
  import la_pkg::*;

  localparam int NWORDS = 1 << LA_ADDR_W;
`ifdef READOUT_CHECKSUM_EN
  localparam int FRAME_BYTES = NWORDS + 1;
`else
  localparam int FRAME_BYTES = NWORDS;
`endif
  localparam int BUDGET = 20000;

  logic                 clk;
  logic                 rst;
  logic                 grant_rd;
  logic                 done_rd;
  logic [LA_ADDR_W-1:0] rd_addr;
  logic                 rd_en;
  logic [7:0]           rd_data;
  logic [7:0]           tx_data;
  logic                 tx_valid;
  logic                 tx_ready;
  logic                 busy;

  readout dut (
    .clk     (clk),
    .rst     (rst),
    .grant_rd(grant_rd),
    .done_rd (done_rd),
    .rd_addr (rd_addr),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .tx_data (tx_data),
    .tx_valid(tx_valid),
    .tx_ready(tx_ready),
    .busy    (busy)
  );

  logic [7:0] ram [0:NWORDS-1];
  logic [7:0] exp_q [$];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;
  int ready_mode = 0;
  int hs_cnt = 0;
  int hs_cyc = 0;
  int done_cnt = 0;
  int rd_en_cnt = 0;
  int fetch_idx = 0;
  logic [7:0] last_byte = '0;
  logic [7:0] prev_data = '0;
  bit stall_prev = 0;
  bit done_prev  = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Registered RAM model: data appears one cycle after rd_en/rd_addr.
  always @(posedge clk) if (rd_en) rd_data <= ram[rd_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_busy"},     32'(busy),     32'd0);
    check({tag, "_rd_addr"},  32'(rd_addr),  32'd0);
    check({tag, "_rd_en"},    32'(rd_en),    32'd0);
    check({tag, "_tx_data"},  32'(tx_data),  32'd0);
    check({tag, "_tx_valid"}, 32'(tx_valid), 32'd0);
    check({tag, "_done_rd"},  32'(done_rd),  32'd0);
  endtask

  task automatic push_frame();
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < NWORDS; i++) begin
      exp_q.push_back(ram[i]);
      s = s + ram[i];
    end
`ifdef READOUT_CHECKSUM_EN
    exp_q.push_back(8'h00 - s);
`endif
  endtask

  task automatic start_frame(input bit hold);
    @(posedge clk);
    #1 grant_rd = 1'b1;
    @(posedge clk);
    #1 if (!hold) grant_rd = 1'b0;
    @(negedge clk);
    check("lat_busy_k", 32'(busy), 32'd1);
    check("lat_valid_k", 32'(tx_valid), 32'd0);
    @(negedge clk);
    check("lat_valid_k1", 32'(tx_valid), 32'd0);
    @(negedge clk);
    check("lat_valid_k2", 32'(tx_valid), 32'd1);
    check("first_byte", 32'(tx_data), 32'(ram[0]));
  endtask

  task automatic wait_done(input int target);
    int n;
    n = 0;
    while (done_cnt < target && n < BUDGET) begin
      @(negedge clk);
      #1 n++;
    end
    check("done_timeout", 32'(done_cnt >= target), 32'd1);
  endtask

  task automatic end_frame(input string tag, input int frames, input int hs0);
    check({tag, "_rd_en_cnt"}, 32'(rd_en_cnt), 32'(NWORDS * frames));
    check({tag, "_bytes"}, 32'(hs_cnt - hs0), 32'(FRAME_BYTES * frames));
    check({tag, "_sb_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    tx_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = (cyc % 4 == 0);
        default: tx_ready = 1'b0;
      endcase
    end
  end

  // Monitor: scoreboard pops, hold-stability, fetch order and done_rd pulse shape.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 0;
      done_prev  = 0;
      fetch_idx  = 0;
    end else begin
      if (rd_en) begin
        check("rd_addr_seq", 32'(rd_addr), 32'(fetch_idx));
        fetch_idx++;
        rd_en_cnt++;
      end
      if (stall_prev) begin
        check("hold_valid", 32'(tx_valid), 32'd1);
        check("hold_data", 32'(tx_data), 32'(prev_data));
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 32'd1);
        else check("tx_byte", 32'(tx_data), 32'(exp_q.pop_front()));
        hs_cnt++;
        hs_cyc    = cyc + 1;
        last_byte = tx_data;
      end
      stall_prev = tx_valid && !tx_ready;
      prev_data  = tx_data;
      if (done_prev) check("done_single", 32'(done_rd), 32'd0);
      if (done_rd) begin
        check("done_after_last_hs", 32'(cyc), 32'(hs_cyc));
        done_cnt++;
        fetch_idx = 0;
      end
      done_prev = done_rd;
    end
  end

  initial begin
    int hs0;
    int n;
    rst = 1'b1;
    grant_rd = 1'b0;
    for (int i = 0; i < NWORDS; i++) ram[i] = i[7:0];
    #23;
    check_reset("reset");
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check_reset("idle");

    // Full frame, tx_ready always high.
    ready_mode = 0; rd_en_cnt = 0; hs0 = hs_cnt;
    push_frame();
    start_frame(0);
    wait_done(1);
    end_frame("f_ready", 1, hs0);
    check("f_ready_last", 32'(last_byte), 32'h000000FF);

    // Same frame with tx_ready high one cycle in four.
    ready_mode = 1; rd_en_cnt = 0; hs0 = hs_cnt;
    push_frame();
    start_frame(0);
    wait_done(2);
    end_frame("f_slow", 1, hs0);

    // Grant dropped after byte 10: the frame still completes.
    ready_mode = 0; rd_en_cnt = 0; hs0 = hs_cnt;
    push_frame();
    start_frame(1);
    n = 0;
    while (hs_cnt < hs0 + 10 && n < BUDGET) begin
      @(negedge clk);
      #1 n++;
    end
    grant_rd = 1'b0;
    wait_done(3);
    end_frame("f_drop", 1, hs0);

    // Grant held: a second frame follows straight after DONE.
    rd_en_cnt = 0; hs0 = hs_cnt;
    push_frame();
    push_frame();
    start_frame(1);
    wait_done(4);
    @(negedge clk);
    check("b2b_idle", 32'(busy), 32'd0);
    @(negedge clk);
    check("b2b_fetch", 32'(rd_en), 32'd1);
    check("b2b_addr0", 32'(rd_addr), 32'd0);
    grant_rd = 1'b0;
    wait_done(5);
    end_frame("f_b2b", 2, hs0);

    // Reset while in SEND at 0x155, then a fresh frame from address 0.
    for (int i = 0; i < NWORDS; i++) ram[i] = 8'(i * 7 + 3);
    push_frame();
    start_frame(0);
    n = 0;
    while (!(rd_en && rd_addr == 10'h155) && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    ready_mode = 2;
    repeat (2) @(negedge clk);
    check("abort_in_send", 32'(tx_valid), 32'd1);
    check("abort_addr", 32'(rd_addr), 32'h155);
    #2 rst = 1'b1;
    #1 check_reset("abort");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ready_mode = 0; rd_en_cnt = 0; hs0 = hs_cnt;
    push_frame();
    start_frame(0);
    wait_done(6);
    end_frame("f_restart", 1, hs0);

    // Last address carries a distinctive byte.
    for (int i = 0; i < NWORDS; i++) ram[i] = i[7:0];
    ram[NWORDS-1] = 8'hAB;
    rd_en_cnt = 0; hs0 = hs_cnt;
    push_frame();
    start_frame(0);
    wait_done(7);
    end_frame("f_bound", 1, hs0);
`ifndef READOUT_CHECKSUM_EN
    check("bound_last_byte", 32'(last_byte), 32'h000000AB);
`endif

`ifdef READOUT_CHECKSUM_EN
    for (int i = 0; i < NWORDS; i++) ram[i] = 8'h01;
    rd_en_cnt = 0; hs0 = hs_cnt;
    push_frame();
    start_frame(0);
    wait_done(8);
    end_frame("f_csum1", 1, hs0);
    check("csum_ones", 32'(last_byte), 32'h00000000);

    for (int i = 0; i < NWORDS; i++) ram[i] = 8'h00;
    ram[0] = 8'h05;
    rd_en_cnt = 0; hs0 = hs_cnt;
    push_frame();
    start_frame(0);
    wait_done(9);
    end_frame("f_csum5", 1, hs0);
    check("csum_five", 32'(last_byte), 32'h000000FB);
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
